// File: rtl/dp_pkg.sv
// rtl/dp_pkg.sv - shared width, function-select codes and flag positions for datapath_unit
package dp_pkg;

   localparam int DP_DW = 16;

   localparam logic [3:0] FS_A     = 4'h0;
   localparam logic [3:0] FS_INC   = 4'h1;
   localparam logic [3:0] FS_ADD   = 4'h2;
   localparam logic [3:0] FS_ADDC  = 4'h3;
   localparam logic [3:0] FS_ADDNB = 4'h4;
   localparam logic [3:0] FS_SUB   = 4'h5;
   localparam logic [3:0] FS_DEC   = 4'h6;
   localparam logic [3:0] FS_TFR   = 4'h7;
   localparam logic [3:0] FS_AND   = 4'h8;
   localparam logic [3:0] FS_OR    = 4'h9;
   localparam logic [3:0] FS_XOR   = 4'hA;
   localparam logic [3:0] FS_NOT   = 4'hB;
   localparam logic [3:0] FS_B     = 4'hC;
   localparam logic [3:0] FS_SHR   = 4'hD;
   localparam logic [3:0] FS_SHL   = 4'hE;
   localparam logic [3:0] FS_ZERO  = 4'hF;

   localparam int FLAG_Z = 0;
   localparam int FLAG_N = 1;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 3;

endpackage

// File: rtl/reg_file_16.sv
// rtl/reg_file_16.sv - 16-entry register file, two combinational reads, one write, async clear
module reg_file_16
   import dp_pkg::*;
#(
   parameter int DW = DP_DW
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          we_i,
   input  logic [3:0]    waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [3:0]    raddr_a_i,
   input  logic [3:0]    raddr_b_i,
   output logic [DW-1:0] rdata_a_o,
   output logic [DW-1:0] rdata_b_o
);

   logic [DW-1:0] regs_q [16];

   // No write-to-read bypass: a same-cycle read sees the pre-edge value.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 16; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i) begin
         regs_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = regs_q[raddr_a_i];
   assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/datapath_unit.sv
// rtl/datapath_unit.sv - register file, function unit and VCNZ flags; DP_SHIFT_EN builds the D/E shifter
module datapath_unit
   import dp_pkg::*;
#(
   parameter int DW = DP_DW
) (
   input  logic          clk_main,
   input  logic          reset,
   input  logic [3:0]    DR,
   input  logic [3:0]    SA,
   input  logic [3:0]    SB,
   input  logic [3:0]    FS,
   input  logic          MB,
   input  logic          MD,
   input  logic          RW,
   input  logic [DW-1:0] DataIn,
   output logic [DW-1:0] BusA,
   output logic [DW-1:0] BusB,
   output logic          V,
   output logic          C,
   output logic          N,
   output logic          Z
);

   logic [DW-1:0] rd_b;
   logic [DW-1:0] b_add;
   logic          cin;
   logic [DW:0]   sum;
   logic [DW-1:0] f;
   logic          c_f;
   logic          v_f;
   logic [DW-1:0] wdata;
   logic [3:0]    flags_q;
   logic [3:0]    flags_d;

   reg_file_16 #(.DW(DW)) u_rf (
      .clk_i     (clk_main),
      .rst_ni    (reset),
      .we_i      (RW),
      .waddr_i   (DR),
      .wdata_i   (wdata),
      .raddr_a_i (SA),
      .raddr_b_i (SB),
      .rdata_a_o (BusA),
      .rdata_b_o (rd_b)
   );

   assign BusB  = MB ? {{(DW-4){1'b0}}, SB} : rd_b;
   assign wdata = MD ? DataIn : f;

   // Every code 0-7 goes through the one adder so carry/overflow come out uniformly.
   always_comb begin
      b_add = '0;
      cin   = 1'b0;
      case (FS)
         FS_INC:   cin = 1'b1;
         FS_ADD:   b_add = BusB;
         FS_ADDC:  begin b_add = BusB;  cin = 1'b1; end
         FS_ADDNB: b_add = ~BusB;
         FS_SUB:   begin b_add = ~BusB; cin = 1'b1; end
         FS_DEC:   b_add = '1;
         default:  ;
      endcase
   end

   assign sum = {1'b0, BusA} + {1'b0, b_add} + {{DW{1'b0}}, cin};

   always_comb begin
      f   = '0;
      c_f = 1'b0;
      v_f = 1'b0;
      case (FS)
         FS_A, FS_INC, FS_ADD, FS_ADDC, FS_ADDNB, FS_SUB, FS_DEC, FS_TFR: begin
            f   = sum[DW-1:0];
            c_f = sum[DW];
            v_f = (BusA[DW-1] == b_add[DW-1]) && (sum[DW-1] != BusA[DW-1]);
         end
         FS_AND:  f = BusA & BusB;
         FS_OR:   f = BusA | BusB;
         FS_XOR:  f = BusA ^ BusB;
         FS_NOT:  f = ~BusA;
         FS_B:    f = BusB;
`ifdef DP_SHIFT_EN
         FS_SHR:  begin f = {1'b0, BusB[DW-1:1]}; c_f = BusB[0];    end
         FS_SHL:  begin f = {BusB[DW-2:0], 1'b0}; c_f = BusB[DW-1]; end
`else
         FS_SHR, FS_SHL: f = BusB;
`endif
         FS_ZERO: f = '0;
         default: f = '0;
      endcase
   end

   // Loads (MD=1) write the register file but leave the flags alone.
   always_comb begin
      flags_d = flags_q;
      if (RW && !MD) begin
         flags_d[FLAG_V] = v_f;
         flags_d[FLAG_C] = c_f;
         flags_d[FLAG_N] = f[DW-1];
         flags_d[FLAG_Z] = (f == '0);
      end
   end

   always_ff @(posedge clk_main or negedge reset) begin
      if (!reset) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign V = flags_q[FLAG_V];
   assign C = flags_q[FLAG_C];
   assign N = flags_q[FLAG_N];
   assign Z = flags_q[FLAG_Z];

endmodule

// File: tb/tb_datapath_unit.sv
// tb/tb_datapath_unit.sv - directed self-checking bench for datapath_unit (DP_SHIFT_EN aware)
module tb_datapath_unit;

   logic        clk_main = 1'b0;
   logic        reset;
   logic [3:0]  DR, SA, SB, FS;
   logic        MB, MD, RW;
   logic [15:0] DataIn;
   logic [15:0] BusA, BusB;
   logic        V, C, N, Z;
   logic [3:0]  vcnz;

   int total = 0;
   int bad   = 0;

   datapath_unit #(.DW(16)) dut (
      .clk_main (clk_main),
      .reset    (reset),
      .DR       (DR),
      .SA       (SA),
      .SB       (SB),
      .FS       (FS),
      .MB       (MB),
      .MD       (MD),
      .RW       (RW),
      .DataIn   (DataIn),
      .BusA     (BusA),
      .BusB     (BusB),
      .V        (V),
      .C        (C),
      .N        (N),
      .Z        (Z)
   );

   always #5 clk_main = ~clk_main;

   assign vcnz = {V, C, N, Z};

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_main);
      #1;
   endtask

   task automatic op(input logic [3:0] dr, input logic [3:0] sa, input logic [3:0] sb,
                     input logic [3:0] fs, input logic mb, input logic md, input logic [15:0] din);
      DR = dr; SA = sa; SB = sb; FS = fs; MB = mb; MD = md; DataIn = din; RW = 1'b1;
      tick();
      RW = 1'b0; MD = 1'b0;
   endtask

   task automatic read_reg(input logic [3:0] idx, input logic [15:0] exp, input string tag);
      RW = 1'b0; SA = idx;
      #1;
      check(tag, BusA, exp);
   endtask

   initial begin
      reset = 1'b1; DR = 0; SA = 0; SB = 0; FS = 0; MB = 0; MD = 0; RW = 0; DataIn = 0;
      #2 reset = 1'b0;
      #1;
      check("reset_r0", BusA, 16'h0000);
      check("reset_flags", {12'h0, vcnz}, 16'h0000);
      tick(); tick();
      reset = 1'b1;
      tick();

      // R1 = 5 via constant; then R2 = R1 + 3
      op(4'd1, 4'd0, 4'd5, 4'hC, 1'b1, 1'b0, 16'h0);
      read_reg(4'd1, 16'h0005, "const_r1");
      DR = 4'd2; SA = 4'd1; SB = 4'd3; FS = 4'h2; MB = 1'b1; MD = 1'b0; RW = 1'b1;
      #1;
      check("busb_const", BusB, 16'h0003);
      tick();
      RW = 1'b0;
      read_reg(4'd2, 16'h0008, "add_r2");
      check("add_flags", {12'h0, vcnz}, 16'h0000);

      // R1 = 8; R4 = R1 - R2 = 0
      op(4'd1, 4'd0, 4'd8, 4'hC, 1'b1, 1'b0, 16'h0);
      SB = 4'd2; MB = 1'b0;
      #1;
      check("busb_reg", BusB, 16'h0008);
      op(4'd4, 4'd1, 4'd2, 4'h5, 1'b0, 1'b0, 16'h0);
      read_reg(4'd4, 16'h0000, "sub_r4");
      check("sub_flags", {12'h0, vcnz}, 16'h0005);

      // Load leaves flags; RW=0 leaves register
      op(4'd3, 4'd0, 4'd0, 4'h0, 1'b0, 1'b1, 16'hBEEF);
      read_reg(4'd3, 16'hBEEF, "load_r3");
      check("load_flags", {12'h0, vcnz}, 16'h0005);
      DR = 4'd3; MD = 1'b1; DataIn = 16'h1234; RW = 1'b0;
      tick();
      MD = 1'b0;
      read_reg(4'd3, 16'hBEEF, "nowrite_r3");
      check("nowrite_flags", {12'h0, vcnz}, 16'h0005);

      // Signed overflow on increment
      op(4'd1, 4'd0, 4'd0, 4'h0, 1'b0, 1'b1, 16'h7FFF);
      op(4'd5, 4'd1, 4'd0, 4'h1, 1'b0, 1'b0, 16'h0);
      read_reg(4'd5, 16'h8000, "inc_r5");
      check("inc_flags", {12'h0, vcnz}, 16'h000A);

      // Same-index read/write: old value until the edge
      DR = 4'd5; SA = 4'd5; FS = 4'hF; MB = 1'b0; MD = 1'b0; RW = 1'b1;
      #1;
      check("rw_same_old", BusA, 16'h8000);
      tick();
      RW = 1'b0;
      #1;
      check("rw_same_new", BusA, 16'h0000);
      check("zero_flags", {12'h0, vcnz}, 16'h0001);

      // Decrement from zero: no carry, N set
      op(4'd7, 4'd4, 4'd0, 4'h6, 1'b0, 1'b0, 16'h0);
      read_reg(4'd7, 16'hFFFF, "dec_r7");
      check("dec_flags", {12'h0, vcnz}, 16'h0002);

      // Shifts of R1 = 8001
      op(4'd1, 4'd0, 4'd0, 4'h0, 1'b0, 1'b1, 16'h8001);
      op(4'd6, 4'd0, 4'd1, 4'hE, 1'b0, 1'b0, 16'h0);
`ifdef DP_SHIFT_EN
      read_reg(4'd6, 16'h0002, "shl_r6");
      check("shl_flags", {12'h0, vcnz}, 16'h0004);
`else
      read_reg(4'd6, 16'h8001, "shl_r6");
      check("shl_flags", {12'h0, vcnz}, 16'h0002);
`endif
      op(4'd8, 4'd0, 4'd1, 4'hD, 1'b0, 1'b0, 16'h0);
`ifdef DP_SHIFT_EN
      read_reg(4'd8, 16'h4000, "shr_r8");
      check("shr_flags", {12'h0, vcnz}, 16'h0004);
`else
      read_reg(4'd8, 16'h8001, "shr_r8");
      check("shr_flags", {12'h0, vcnz}, 16'h0002);
`endif

      // XOR of R3 with R1
      op(4'd9, 4'd3, 4'd1, 4'hA, 1'b0, 1'b0, 16'h0);
      read_reg(4'd9, 16'h3EEE, "xor_r9");
      check("xor_flags", {12'h0, vcnz}, 16'h0000);

      // Flags nonzero before reset; reset mid-cycle overrides pending write
      op(4'd10, 4'd7, 4'd0, 4'hB, 1'b0, 1'b0, 16'h0);
      read_reg(4'd10, 16'h0000, "not_r10");
      check("not_flags", {12'h0, vcnz}, 16'h0001);
      SA = 4'd3; DR = 4'd3; MD = 1'b1; DataIn = 16'h5555; RW = 1'b1;
      #2 reset = 1'b0;
      #1;
      check("midreset_r3", BusA, 16'h0000);
      check("midreset_flags", {12'h0, vcnz}, 16'h0000);
      tick();
      check("heldreset_r3", BusA, 16'h0000);
      RW = 1'b0; MD = 1'b0;
      reset = 1'b1;
      read_reg(4'd9, 16'h0000, "postreset_r9");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
